// File: rtl/frame_word_packer.sv
// Hunts for a two-byte header in a UART byte stream, buffers NWORDS big-endian words and replays them.
// Optional feature: define CHECKSUM_EN to require a trailing sum-mod-256 byte before the frame is replayed.
module frame_word_packer #(
   parameter int          NWORDS  = 6,
   parameter logic [7:0]  HDR0    = 8'hA5,
   parameter logic [7:0]  HDR1    = 8'h5A,
   parameter int          TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [15:0] data_out,
   output logic        pi_flag,
   output logic        frame_ok,
   output logic        frame_err,
   output logic        busy
);

   localparam int NBYTES = 2 * NWORDS;
   localparam int BW     = $clog2(NBYTES + 1);
   localparam int WW     = $clog2(NWORDS + 1);
   localparam int TW     = $clog2(TIMEOUT);

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, H1, PAY, CSUM, EMIT} state_t;
`else
   typedef enum logic [2:0] {IDLE, H1, PAY, EMIT} state_t;
`endif

   state_t          state_q;
   logic [BW-1:0]   byteCnt_q;
   logic [WW-1:0]   wordIdx_q;
   logic [TW-1:0]   tout_q;
   logic [TW-1:0]   tout_d;
   logic [15:0]     wordBuf_q [NWORDS];
   logic [15:0]     dataOut_q;
   logic            piFlag_q;
   logic            frameOk_q;
   logic            frameErr_q;
   logic            inFrame;
   logic            toutFire;
   logic [BW-2:0]   wordSel;
`ifdef CHECKSUM_EN
   logic [7:0]      sum_q;
`endif

   // Timeout counter saturates at TIMEOUT-1; the abort fires on the edge that would make it reach that value.
   always_comb begin
      tout_d   = (tout_q == TW'(TIMEOUT - 1)) ? tout_q : tout_q + 1'b1;
      toutFire = (tout_q == TW'(TIMEOUT - 2));
      wordSel  = byteCnt_q[BW-1:1];
`ifdef CHECKSUM_EN
      inFrame  = (state_q == H1) || (state_q == PAY) || (state_q == CSUM);
`else
      inFrame  = (state_q == H1) || (state_q == PAY);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         byteCnt_q  <= '0;
         wordIdx_q  <= '0;
         tout_q     <= '0;
         dataOut_q  <= '0;
         piFlag_q   <= 1'b0;
         frameOk_q  <= 1'b0;
         frameErr_q <= 1'b0;
`ifdef CHECKSUM_EN
         sum_q      <= '0;
`endif
         for (int i = 0; i < NWORDS; i++) begin
            wordBuf_q[i] <= '0;
         end
      end else begin
         piFlag_q   <= 1'b0;
         frameOk_q  <= 1'b0;
         frameErr_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (rx_valid && rx_data == HDR0) begin
                  state_q <= H1;
               end
            end
            H1: begin
               if (rx_valid) begin
                  if (rx_data == HDR1) begin
                     state_q   <= PAY;
                     byteCnt_q <= '0;
`ifdef CHECKSUM_EN
                     sum_q     <= '0;
`endif
                  end else if (rx_data != HDR0) begin
                     state_q <= IDLE;
                  end
               end
            end
            PAY: begin
               if (rx_valid) begin
                  if (byteCnt_q[0] == 1'b0) begin
                     wordBuf_q[wordSel][15:8] <= rx_data;
                  end else begin
                     wordBuf_q[wordSel][7:0] <= rx_data;
                  end
`ifdef CHECKSUM_EN
                  sum_q <= sum_q + rx_data;
`endif
                  if (byteCnt_q == BW'(NBYTES - 1)) begin
                     byteCnt_q <= '0;
                     wordIdx_q <= '0;
`ifdef CHECKSUM_EN
                     state_q   <= CSUM;
`else
                     state_q   <= EMIT;
`endif
                  end else begin
                     byteCnt_q <= byteCnt_q + 1'b1;
                  end
               end
            end
`ifdef CHECKSUM_EN
            CSUM: begin
               if (rx_valid) begin
                  if (rx_data == sum_q) begin
                     state_q   <= EMIT;
                     wordIdx_q <= '0;
                  end else begin
                     frameErr_q <= 1'b1;
                     state_q    <= IDLE;
                  end
               end
            end
`endif
            // Bytes arriving during replay are dropped; the store sees one word per cycle.
            EMIT: begin
               if (wordIdx_q == WW'(NWORDS)) begin
                  frameOk_q <= 1'b1;
                  wordIdx_q <= '0;
                  state_q   <= IDLE;
               end else begin
                  piFlag_q  <= 1'b1;
                  dataOut_q <= wordBuf_q[wordIdx_q];
                  wordIdx_q <= wordIdx_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         // A byte arriving on the expiry cycle wins over the abort.
         if (inFrame && !rx_valid) begin
            if (toutFire) begin
               frameErr_q <= 1'b1;
               state_q    <= IDLE;
               tout_q     <= '0;
            end else begin
               tout_q <= tout_d;
            end
         end else begin
            tout_q <= '0;
         end
      end
   end

   assign data_out  = dataOut_q;
   assign pi_flag   = piFlag_q;
   assign frame_ok  = frameOk_q;
   assign frame_err = frameErr_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_frame_word_packer.sv
// Self-checking bench for frame_word_packer: random payloads compared against a byte-level frame model.
module tb_frame_word_packer;

   localparam int NW = 6;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [15:0] data_out;
   logic        pi_flag;
   logic        frame_ok;
   logic        frame_err;
   logic        busy;

   int nChecks = 0;
   int nFail   = 0;
   int cyc     = 0;
   int lastCyc;

   logic [15:0] gotWords [$];
   int          gotCyc   [$];
   int          okCnt, okCyc, errCnt, errCyc;
   logic [7:0]  pay [2*NW];

   frame_word_packer #(.NWORDS(NW), .HDR0(8'hA5), .HDR1(8'h5A), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .data_out  (data_out),
      .pi_flag   (pi_flag),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observed strobes are collected on the falling edge, halfway between active edges.
   always @(negedge clk) begin
      if (pi_flag) begin
         gotWords.push_back(data_out);
         gotCyc.push_back(cyc);
      end
      if (frame_ok) begin
         okCnt++;
         okCyc = cyc;
      end
      if (frame_err) begin
         errCnt++;
         errCyc = cyc;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [15:0] modelWord(input int i);
      return {pay[2*i], pay[2*i+1]};
   endfunction

   function automatic logic [7:0] modelSum();
      int s = 0;
      for (int i = 0; i < 2*NW; i++) s += pay[i];
      return 8'(s % 256);
   endfunction

   task automatic clearObs();
      gotWords.delete();
      gotCyc.delete();
      okCnt = 0; errCnt = 0; okCyc = -1; errCyc = -1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      lastCyc  = cyc;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic randomPayload();
      for (int i = 0; i < 2*NW; i++) pay[i] = 8'($urandom);
   endtask

   task automatic sendBody(input logic corrupt);
      for (int i = 0; i < 2*NW; i++) applyStimulus(pay[i]);
`ifdef CHECKSUM_EN
      applyStimulus(modelSum() + (corrupt ? 8'd1 : 8'd0));
`else
      if (corrupt) $display("[TB] note: checksum not built, corrupt flag ignored");
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      idleCycles(3);
      nChecks++; if (data_out !== 16'h0) begin nFail++; $display("[TB] FAIL reset_data_out: got %h expected 0000", data_out); end
      nChecks++; if (pi_flag !== 1'b0) begin nFail++; $display("[TB] FAIL reset_pi_flag: got %b expected 0", pi_flag); end
      nChecks++; if (frame_ok !== 1'b0) begin nFail++; $display("[TB] FAIL reset_frame_ok: got %b expected 0", frame_ok); end
      nChecks++; if (frame_err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b0;
      idleCycles(1);
   endtask

   task automatic test_good_frame();
      logic [7:0] fixed [2*NW] = '{8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30,
                                   8'h00, 8'h40, 8'h01, 8'h00, 8'h02, 8'h00};
      logic [15:0] got;
      pay = fixed;
      clearObs();
      applyStimulus(8'hA5);
      applyStimulus(8'h5A);
      sendBody(1'b0);
      idleCycles(NW + 4);
      nChecks++; if (gotWords.size() !== NW) begin nFail++; $display("[TB] FAIL good_count: got %0d words expected %0d", gotWords.size(), NW); end
      for (int i = 0; i < NW; i++) begin
         got = (i < gotWords.size()) ? gotWords[i] : 16'hxxxx;
         nChecks++; if (got !== modelWord(i)) begin nFail++; $display("[TB] FAIL good_word%0d: got %h expected %h", i, got, modelWord(i)); end
      end
      if (gotWords.size() == NW) begin
         nChecks++; if (gotCyc[0] !== lastCyc + 1) begin nFail++; $display("[TB] FAIL good_first_latency: got cycle %0d expected %0d", gotCyc[0], lastCyc + 1); end
         nChecks++; if (gotCyc[NW-1] !== lastCyc + NW) begin nFail++; $display("[TB] FAIL good_last_latency: got cycle %0d expected %0d", gotCyc[NW-1], lastCyc + NW); end
      end
      nChecks++; if (okCnt !== 1) begin nFail++; $display("[TB] FAIL good_ok_count: got %0d expected 1", okCnt); end
      nChecks++; if (okCyc !== lastCyc + NW + 1) begin nFail++; $display("[TB] FAIL good_ok_cycle: got %0d expected %0d", okCyc, lastCyc + NW + 1); end
      nChecks++; if (errCnt !== 0) begin nFail++; $display("[TB] FAIL good_err_count: got %0d expected 0", errCnt); end
      nChecks++; if (data_out !== modelWord(NW-1)) begin nFail++; $display("[TB] FAIL good_hold: got %h expected %h", data_out, modelWord(NW-1)); end
   endtask

   task automatic test_checksum_or_stray();
      logic [15:0] got;
      randomPayload();
      clearObs();
`ifdef CHECKSUM_EN
      applyStimulus(8'hA5);
      applyStimulus(8'h5A);
      sendBody(1'b1);
      idleCycles(NW + 4);
      nChecks++; if (errCnt !== 1) begin nFail++; $display("[TB] FAIL badcs_err_count: got %0d expected 1", errCnt); end
      nChecks++; if (errCyc !== lastCyc) begin nFail++; $display("[TB] FAIL badcs_err_cycle: got %0d expected %0d", errCyc, lastCyc); end
      nChecks++; if (gotWords.size() !== 0) begin nFail++; $display("[TB] FAIL badcs_no_words: got %0d expected 0", gotWords.size()); end
      nChecks++; if (okCnt !== 0) begin nFail++; $display("[TB] FAIL badcs_ok_count: got %0d expected 0", okCnt); end
      randomPayload();
      clearObs();
      applyStimulus(8'hA5);
      applyStimulus(8'h5A);
      sendBody(1'b0);
      idleCycles(NW + 4);
`else
      applyStimulus(8'hA5);
      applyStimulus(8'h5A);
      sendBody(1'b0);
      idleCycles(NW + 4);
      applyStimulus(8'h33);
      idleCycles(3);
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL stray_busy: got %b expected 0", busy); end
`endif
      nChecks++; if (gotWords.size() !== NW) begin nFail++; $display("[TB] FAIL after_count: got %0d words expected %0d", gotWords.size(), NW); end
      for (int i = 0; i < NW; i++) begin
         got = (i < gotWords.size()) ? gotWords[i] : 16'hxxxx;
         nChecks++; if (got !== modelWord(i)) begin nFail++; $display("[TB] FAIL after_word%0d: got %h expected %h", i, got, modelWord(i)); end
      end
      nChecks++; if (okCnt !== 1) begin nFail++; $display("[TB] FAIL after_ok_count: got %0d expected 1", okCnt); end
   endtask

   task automatic test_resync();
      logic [15:0] got;
      randomPayload();
      clearObs();
      applyStimulus(8'h12);
      applyStimulus(8'hA5);
      applyStimulus(8'hA5);
      applyStimulus(8'h5A);
      sendBody(1'b0);
      idleCycles(NW + 4);
      nChecks++; if (gotWords.size() !== NW) begin nFail++; $display("[TB] FAIL resync_count: got %0d words expected %0d", gotWords.size(), NW); end
      for (int i = 0; i < NW; i++) begin
         got = (i < gotWords.size()) ? gotWords[i] : 16'hxxxx;
         nChecks++; if (got !== modelWord(i)) begin nFail++; $display("[TB] FAIL resync_word%0d: got %h expected %h", i, got, modelWord(i)); end
      end
      nChecks++; if (okCnt !== 1) begin nFail++; $display("[TB] FAIL resync_ok_count: got %0d expected 1", okCnt); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got;
      for (int f = 0; f < 5; f++) begin
         randomPayload();
         if (f == 0) begin
            pay[0] = 8'hA5; pay[1] = 8'h5A;
         end
         clearObs();
         applyStimulus(8'hA5);
         applyStimulus(8'h5A);
         sendBody(1'b0);
         idleCycles(NW + 2 + $urandom_range(0, 4));
         nChecks++; if (gotWords.size() !== NW) begin nFail++; $display("[TB] FAIL b2b%0d_count: got %0d words expected %0d", f, gotWords.size(), NW); end
         for (int i = 0; i < NW; i++) begin
            got = (i < gotWords.size()) ? gotWords[i] : 16'hxxxx;
            nChecks++; if (got !== modelWord(i)) begin nFail++; $display("[TB] FAIL b2b%0d_word%0d: got %h expected %h", f, i, got, modelWord(i)); end
         end
         nChecks++; if (okCnt !== 1 || errCnt !== 0) begin nFail++; $display("[TB] FAIL b2b%0d_status: got ok=%0d err=%0d expected ok=1 err=0", f, okCnt, errCnt); end
      end
   endtask

   task automatic test_timeout();
      logic [15:0] got;
      clearObs();
      applyStimulus(8'hA5);
      applyStimulus(8'h5A);
      applyStimulus(8'h00);
      idleCycles(TO - 2);
      nChecks++; if (busy !== 1'b1 || errCnt !== 0) begin nFail++; $display("[TB] FAIL timeout_early: got busy=%b err=%0d expected busy=1 err=0", busy, errCnt); end
      idleCycles(1);
      nChecks++; if (frame_err !== 1'b1) begin nFail++; $display("[TB] FAIL timeout_pulse: got %b expected 1", frame_err); end
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL timeout_busy: got %b expected 0", busy); end
      idleCycles(NW + 4);
      nChecks++; if (errCnt !== 1 || gotWords.size() !== 0) begin nFail++; $display("[TB] FAIL timeout_totals: got err=%0d words=%0d expected err=1 words=0", errCnt, gotWords.size()); end

      // Every byte lands on the very cycle the abort would fire.
      randomPayload();
      clearObs();
      applyStimulus(8'hA5);
      applyStimulus(8'h5A);
      for (int i = 0; i < 2*NW; i++) begin
         idleCycles(TO - 2);
         applyStimulus(pay[i]);
      end
`ifdef CHECKSUM_EN
      idleCycles(TO - 2);
      applyStimulus(modelSum());
`endif
      idleCycles(NW + 4);
      nChecks++; if (errCnt !== 0) begin nFail++; $display("[TB] FAIL late_byte_err: got %0d expected 0", errCnt); end
      nChecks++; if (gotWords.size() !== NW) begin nFail++; $display("[TB] FAIL late_byte_count: got %0d expected %0d", gotWords.size(), NW); end
      for (int i = 0; i < NW; i++) begin
         got = (i < gotWords.size()) ? gotWords[i] : 16'hxxxx;
         nChecks++; if (got !== modelWord(i)) begin nFail++; $display("[TB] FAIL late_byte_word%0d: got %h expected %h", i, got, modelWord(i)); end
      end
   endtask

   task automatic test_reset_mid_emit();
      int guard = 0;
      randomPayload();
      clearObs();
      applyStimulus(8'hA5);
      applyStimulus(8'h5A);
      sendBody(1'b0);
      while (gotWords.size() < 3 && guard < 40) begin
         @(negedge clk);
         #2;
         guard++;
      end
      nChecks++; if (gotWords.size() < 3) begin nFail++; $display("[TB] FAIL midemit_wait: got %0d words expected 3 within 40 cycles", gotWords.size()); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      nChecks++; if (pi_flag !== 1'b0 || data_out !== 16'h0 || frame_ok !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL midemit_outputs: got pi=%b data=%h ok=%b err=%b busy=%b expected all 0", pi_flag, data_out, frame_ok, frame_err, busy);
      end
      rst = 1'b0;
      idleCycles(NW + 4);
      nChecks++; if (gotWords.size() !== 3 || okCnt !== 0) begin nFail++; $display("[TB] FAIL midemit_stopped: got words=%0d ok=%0d expected words=3 ok=0", gotWords.size(), okCnt); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_checksum_or_stray();
      test_resync();
      test_back_to_back();
      test_timeout();
      test_reset_mid_emit();
      test_good_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
